lcd_timing_rx: RTL and testbench

Receive-side monitor for the parallel RGB565 LCD interface that the video generator drives (DE/HSYNC/VSYNC plus 5/6/5 colour). It runs on the pixel clock and samples the same pins the panel sees, either in loopback on the Tang Nano or on an external capture. It produces per-pixel coordinates, the measured active geometry, a per-frame checksum and a lock/error status. These outputs are used for self-test of the video path and as a pixel-coordinate source for overlay logic.

---
 rtl/lcd_rx_pkg.sv | 26 ++
 rtl/sig_edge.sv | 30 +++
 rtl/lcd_timing_rx.sv | 172 +++++++++++++++++
 tb/tb_lcd_timing_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_rx_pkg.sv
// Shared types and constants for the RGB565 LCD timing receiver.
// Holds the controller states, default counter widths and the checksum step.
package lcd_rx_pkg;

    typedef enum logic {
        SEEK  = 1'b0,
        FRAME = 1'b1
    } state_t;

    localparam int DEF_XW = 11;
    localparam int DEF_YW = 10;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int RGB_W = R_W + G_W + B_W;

    localparam logic [RGB_W-1:0] CRC_SEED = '0;

    // Rotate-left-by-one then fold in the pixel.
    function automatic logic [RGB_W-1:0] crc_step(input logic [RGB_W-1:0] crc,
                                                  input logic [RGB_W-1:0] rgb);
        return {crc[RGB_W-2:0], crc[RGB_W-1]} ^ rgb;
    endfunction

endpackage

// File: rtl/sig_edge.sv
// Registers one timing pin, normalises it to an active-high level and
// reports single-cycle assert (rise) and deassert (fall) pulses.
module sig_edge #(
    parameter bit POL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            level <= pin ^ ~POL;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/lcd_timing_rx.sv
// Receive-side monitor for a DE/HSYNC/VSYNC RGB565 LCD stream: pixel
// coordinates, measured geometry, per-frame checksum and lock/error status.
module lcd_timing_rx
    import lcd_rx_pkg::*;
#(
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int XW          = DEF_XW,
    parameter int YW          = DEF_YW,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LCD_DE,
    input  logic             LCD_HSYNC,
    input  logic             LCD_VSYNC,
    input  logic [R_W-1:0]   LCD_R,
    input  logic [G_W-1:0]   LCD_G,
    input  logic [B_W-1:0]   LCD_B,
    output logic             PIX_VALID,
    output logic [XW-1:0]    PIX_X,
    output logic [YW-1:0]    PIX_Y,
    output logic [RGB_W-1:0] PIX_RGB,
    output logic [XW-1:0]    H_ACTIVE,
    output logic [YW-1:0]    V_ACTIVE,
    output logic [YW-1:0]    V_TOTAL,
    output logic [RGB_W-1:0] FRAME_CRC,
    output logic [7:0]       FRAME_CNT,
    output logic             FRAME_DONE,
    output logic             LOCKED,
    output logic             ERR_GEOM
);

    localparam int            MW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] LOCK_LVL = MW'(LOCK_FRAMES);

    logic de, de_rise, de_fall;
    logic hs_level, hs_rise, hs_fall;
    logic vs_level, vs_rise, vs_fall;
    logic unused_edges;

    sig_edge #(.POL(1'b1)) u_de (
        .clk(CLK), .rst(RESET), .pin(LCD_DE),
        .level(de), .rise(de_rise), .fall(de_fall)
    );

    sig_edge #(.POL(HS_POL)) u_hs (
        .clk(CLK), .rst(RESET), .pin(LCD_HSYNC),
        .level(hs_level), .rise(hs_rise), .fall(hs_fall)
    );

    sig_edge #(.POL(VS_POL)) u_vs (
        .clk(CLK), .rst(RESET), .pin(LCD_VSYNC),
        .level(vs_level), .rise(vs_rise), .fall(vs_fall)
    );

    assign unused_edges = ^{de_rise, hs_level, hs_fall, vs_level, vs_fall};

    logic [RGB_W-1:0] rgb_q;

    always_ff @(posedge CLK) begin
        if (RESET) rgb_q <= '0;
        else       rgb_q <= {LCD_R, LCD_G, LCD_B};
    end

    state_t           state;
    logic [XW-1:0]    x, wref;
    logic [YW-1:0]    y, hcnt;
    logic             mism;
    logic             have_prev;
    logic [RGB_W-1:0] crc;
    logic [MW-1:0]    match;

    logic             in_frame, run, pix, close, line_end, x_max;
    logic             mism_end, geom_same, frame_err;
    logic [XW-1:0]    wref_end, x_base, wref_base;
    logic [YW-1:0]    y_end, y_base, hcnt_base;
    logic             mism_base;
    logic [RGB_W-1:0] crc_base;
    logic [MW-1:0]    match_next;

    // A line end coinciding with VSYNC still belongs to the closing frame
    // (the *_end values); a pixel or HSYNC in that cycle starts the new one.
    // NOTE: always_comb assigns every output up front, so no latch can be inferred.
    always_comb begin
        in_frame  = (state == FRAME);
        run       = in_frame | vs_rise;
        pix       = run & de;
        close     = in_frame & vs_rise;
        line_end  = in_frame & de_fall;

        wref_end  = (line_end && y == '0) ? x : wref;
        mism_end  = mism | (line_end && y != '0 && x != wref);
        y_end     = y + YW'(line_end);

        x_base    = (vs_rise || de_fall || hs_rise) ? '0 : x;
        y_base    = vs_rise ? '0 : y_end;
        wref_base = vs_rise ? '0 : wref_end;
        mism_base = vs_rise ? 1'b0 : mism_end;
        hcnt_base = (vs_rise ? '0 : hcnt) + YW'(hs_rise);
        crc_base  = vs_rise ? CRC_SEED : crc;
        x_max     = &x_base;

        frame_err = (y_end == '0) || mism_end;
        geom_same = have_prev && (wref_end == H_ACTIVE) &&
                    (y_end == V_ACTIVE) && (hcnt == V_TOTAL);

        match_next = '0;
        if (!frame_err && geom_same)
            match_next = (match == LOCK_LVL) ? match : match + MW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= SEEK;
            x          <= '0;
            y          <= '0;
            wref       <= '0;
            hcnt       <= '0;
            mism       <= 1'b0;
            crc        <= CRC_SEED;
            match      <= '0;
            have_prev  <= 1'b0;
            PIX_VALID  <= 1'b0;
            PIX_X      <= '0;
            PIX_Y      <= '0;
            PIX_RGB    <= '0;
            H_ACTIVE   <= '0;
            V_ACTIVE   <= '0;
            V_TOTAL    <= '0;
            FRAME_CRC  <= '0;
            FRAME_CNT  <= '0;
            FRAME_DONE <= 1'b0;
            LOCKED     <= 1'b0;
            ERR_GEOM   <= 1'b0;
        end else begin
            FRAME_DONE <= close;
            PIX_VALID  <= pix;

            if (pix) begin
                PIX_X   <= x_base;
                PIX_Y   <= y_base;
                PIX_RGB <= rgb_q;
                if (x_max) ERR_GEOM <= 1'b1;
            end

            if (run) begin
                x    <= (pix && !x_max) ? x_base + XW'(1) : x_base;
                y    <= y_base;
                wref <= wref_base;
                mism <= mism_base;
                hcnt <= hcnt_base;
                crc  <= pix ? crc_step(crc_base, rgb_q) : crc_base;
            end

            if (close) begin
                H_ACTIVE  <= wref_end;
                V_ACTIVE  <= y_end;
                V_TOTAL   <= hcnt;
                FRAME_CRC <= crc;
                FRAME_CNT <= FRAME_CNT + 8'd1;
                match     <= match_next;
                LOCKED    <= (match_next == LOCK_LVL);
                have_prev <= 1'b1;
                if (frame_err) ERR_GEOM <= 1'b1;
            end

            if (vs_rise) state <= FRAME;
        end
    end

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Directed bench for lcd_timing_rx: geometry, pixel path, checksum, lock,
// error stickiness, mid-frame reset, sync polarity and coincident edges.
module tb_lcd_timing_rx;

    localparam int LINE = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        de = 1'b0, hs_a = 1'b0, vs_a = 1'b0;
    logic [4:0]  r = '0, b = '0;
    logic [5:0]  g = '0;
    logic        hs_low, vs_low;
    assign hs_low = ~hs_a;
    assign vs_low = ~vs_a;

    logic        p1_valid, p1_done, p1_locked, p1_err;
    logic [10:0] p1_x, p1_h;
    logic [9:0]  p1_y, p1_v, p1_vt;
    logic [15:0] p1_rgb, p1_crc;
    logic [7:0]  p1_cnt;

    logic        p2_valid, p2_done, p2_locked, p2_err;
    logic [10:0] p2_x, p2_h;
    logic [9:0]  p2_y, p2_v, p2_vt;
    logic [15:0] p2_rgb, p2_crc;
    logic [7:0]  p2_cnt;

    lcd_timing_rx dut1 (
        .CLK(clk), .RESET(rst), .LCD_DE(de), .LCD_HSYNC(hs_low), .LCD_VSYNC(vs_low),
        .LCD_R(r), .LCD_G(g), .LCD_B(b),
        .PIX_VALID(p1_valid), .PIX_X(p1_x), .PIX_Y(p1_y), .PIX_RGB(p1_rgb),
        .H_ACTIVE(p1_h), .V_ACTIVE(p1_v), .V_TOTAL(p1_vt), .FRAME_CRC(p1_crc),
        .FRAME_CNT(p1_cnt), .FRAME_DONE(p1_done), .LOCKED(p1_locked), .ERR_GEOM(p1_err)
    );

    lcd_timing_rx #(.HS_POL(1'b1), .VS_POL(1'b1)) dut2 (
        .CLK(clk), .RESET(rst), .LCD_DE(de), .LCD_HSYNC(hs_a), .LCD_VSYNC(vs_a),
        .LCD_R(r), .LCD_G(g), .LCD_B(b),
        .PIX_VALID(p2_valid), .PIX_X(p2_x), .PIX_Y(p2_y), .PIX_RGB(p2_rgb),
        .H_ACTIVE(p2_h), .V_ACTIVE(p2_v), .V_TOTAL(p2_vt), .FRAME_CRC(p2_crc),
        .FRAME_CNT(p2_cnt), .FRAME_DONE(p2_done), .LOCKED(p2_locked), .ERR_GEOM(p2_err)
    );

    int errors = 0;
    int checks = 0;

    // FRAME_DONE snapshots for both instances, indexed by pulse number.
    int          done1 = 0, done2 = 0;
    logic [10:0] s1_h [16], s2_h [16];
    logic [9:0]  s1_v [16], s2_v [16], s1_vt [16], s2_vt [16];
    logic [15:0] s2_crc [16];
    logic [7:0]  s1_cnt [16], s2_cnt [16];
    logic        s1_lk [16], s2_lk [16], s2_er [16];

    always @(negedge clk) begin
        if (p1_done) begin
            if (done1 < 16) begin
                s1_h[done1] = p1_h; s1_v[done1] = p1_v; s1_vt[done1] = p1_vt;
                s1_cnt[done1] = p1_cnt; s1_lk[done1] = p1_locked;
            end
            done1++;
        end
        if (p2_done) begin
            if (done2 < 16) begin
                s2_h[done2] = p2_h; s2_v[done2] = p2_v; s2_vt[done2] = p2_vt;
                s2_crc[done2] = p2_crc; s2_cnt[done2] = p2_cnt;
                s2_lk[done2] = p2_locked; s2_er[done2] = p2_err;
            end
            done2++;
        end
    end

    // Three-deep history of what was driven, for the 2-cycle pixel latency.
    logic        h_de [3] = '{default: 1'b0};
    logic [10:0] h_x  [3] = '{default: '0};
    logic [9:0]  h_y  [3] = '{default: '0};
    logic [15:0] h_rgb[3] = '{default: '0};

    logic [15:0] model_crc = '0;
    logic [15:0] last_crc  = '0;

    task automatic cyc(input logic d, input logic h, input logic v,
                       input logic [15:0] c, input int ex, input int ey);
        @(negedge clk);
        for (int k = 2; k > 0; k--) begin
            h_de[k] = h_de[k-1]; h_x[k] = h_x[k-1]; h_y[k] = h_y[k-1]; h_rgb[k] = h_rgb[k-1];
        end
        h_de[0] = d; h_x[0] = 11'(ex); h_y[0] = 10'(ey); h_rgb[0] = c;
        de = d; hs_a = h; vs_a = v;
        {r, g, b} = c;
    endtask

    // One line: HSYNC for cycles 0-1, DE for w cycles from column start.
    task automatic send_line(input int w, input int start, input logic v,
                             input int ay, input logic chk);
        for (int c = 0; c < LINE; c++) begin
            logic        d;
            logic [15:0] col;
            d   = (w > 0) && (c >= start) && (c < start + w);
            col = 16'((c - start) + 16 * ay);
            cyc(d, c < 2, v, col, c - start, ay);
            if (d) model_crc = {model_crc[14:0], model_crc[15]} ^ col;
            if (chk) begin
                checks++;
                if (p1_valid !== h_de[2]) begin
                    errors++;
                    $display("FAIL pix_valid: got %0b want %0b at col %0d", p1_valid, h_de[2], c);
                end else if (h_de[2]) begin
                    checks++;
                    if ({p1_x, p1_y, p1_rgb} !== {h_x[2], h_y[2], h_rgb[2]}) begin
                        errors++;
                        $display("FAIL pix_xy: got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                                 p1_x, p1_y, p1_rgb, h_x[2], h_y[2], h_rgb[2]);
                    end
                end
            end
        end
    endtask

    // 6-line frame, VSYNC on line 0, DE on lines 1-4 (w2 = width of line 2).
    // coinc also puts DE on line 5 ending on the last cycle before next VSYNC.
    task automatic send_frame(input int w2, input logic chk, input logic coinc);
        last_crc  = model_crc;
        model_crc = '0;
        for (int l = 0; l < 6; l++) begin
            int w;
            w = (l == 0 || (l == 5 && !coinc)) ? 0 : (l == 2 ? w2 : 16);
            send_line(w, (coinc && l == 5) ? 8 : 4, l == 0, l - 1, chk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
        checks++;
        if ({p1_valid, p1_x, p1_y, p1_rgb} !== '0) begin
            errors++; $display("FAIL reset_pix: got %b want 0", {p1_valid, p1_x, p1_y, p1_rgb});
        end
        checks++;
        if ({p1_h, p1_v, p1_vt, p1_crc} !== '0) begin
            errors++; $display("FAIL reset_geom: got %h want 0", {p1_h, p1_v, p1_vt, p1_crc});
        end
        checks++;
        if ({p1_cnt, p1_done, p1_locked, p1_err} !== '0) begin
            errors++; $display("FAIL reset_status: got %b want 0", {p1_cnt, p1_done, p1_locked, p1_err});
        end
        checks++;
        if ({p2_valid, p2_h, p2_v, p2_vt, p2_crc, p2_cnt, p2_done, p2_locked, p2_err} !== '0) begin
            errors++; $display("FAIL reset_dut2: got nonzero outputs want 0");
        end
        rst = 1'b0;
    endtask

    task automatic test_geometry;
        repeat (4) send_frame(16, 1'b0, 1'b0);
        checks++;
        if (done1 != 3) begin errors++; $display("FAIL geom_dones: got %0d want 3", done1); end
        checks++;
        if ({s1_h[0], s1_v[0], s1_vt[0]} !== {11'd16, 10'd4, 10'd6}) begin
            errors++; $display("FAIL geom_first: got H=%0d V=%0d VT=%0d want 16 4 6", s1_h[0], s1_v[0], s1_vt[0]);
        end
        checks++;
        if ({s1_lk[0], s1_lk[1], s1_lk[2]} !== 3'b001) begin
            errors++; $display("FAIL geom_lock_seq: got %b want 001", {s1_lk[0], s1_lk[1], s1_lk[2]});
        end
        checks++;
        if (p1_cnt !== 8'd3) begin errors++; $display("FAIL geom_cnt: got %0d want 3", p1_cnt); end
        checks++;
        if ({p1_locked, p1_err} !== 2'b10) begin
            errors++; $display("FAIL geom_status: got lock/err=%b want 10", {p1_locked, p1_err});
        end
    endtask

    task automatic test_pixel;
        send_frame(16, 1'b1, 1'b0);
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if (p1_crc !== last_crc) begin
            errors++; $display("FAIL pix_crc: got %h want %h", p1_crc, last_crc);
        end
        checks++;
        if (p1_cnt !== 8'd5) begin errors++; $display("FAIL pix_cnt: got %0d want 5", p1_cnt); end
    endtask

    task automatic test_error;
        send_frame(15, 1'b0, 1'b0);
        checks++;
        if ({p1_locked, p1_err} !== 2'b10) begin
            errors++; $display("FAIL err_before: got lock/err=%b want 10", {p1_locked, p1_err});
        end
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if ({p1_locked, p1_err, p1_h, p1_v} !== {2'b01, 11'd16, 10'd4}) begin
            errors++; $display("FAIL err_bad_frame: got lock/err=%b H=%0d V=%0d want 01 16 4",
                               {p1_locked, p1_err}, p1_h, p1_v);
        end
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if ({p1_locked, p1_err} !== 2'b01) begin
            errors++; $display("FAIL err_good1: got lock/err=%b want 01", {p1_locked, p1_err});
        end
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if ({p1_locked, p1_err} !== 2'b11) begin
            errors++; $display("FAIL err_relock: got lock/err=%b want 11", {p1_locked, p1_err});
        end
    endtask

    task automatic test_polarity;
        checks++;
        if (done2 != done1) begin errors++; $display("FAIL pol_dones: got %0d want %0d", done2, done1); end
        checks++;
        if ({s2_h[0], s2_v[0], s2_vt[0]} !== {11'd16, 10'd4, 10'd6}) begin
            errors++; $display("FAIL pol_first: got H=%0d V=%0d VT=%0d want 16 4 6", s2_h[0], s2_v[0], s2_vt[0]);
        end
        checks++;
        if ({s2_lk[2], s2_cnt[2]} !== {1'b1, 8'd3}) begin
            errors++; $display("FAIL pol_lock: got lock=%b cnt=%0d want 1 3", s2_lk[2], s2_cnt[2]);
        end
        checks++;
        if (s2_crc[0] !== last_crc) begin
            errors++; $display("FAIL pol_crc: got %h want %h", s2_crc[0], last_crc);
        end
        checks++;
        if ({s2_er[5], s2_er[6], s2_lk[6]} !== 3'b010) begin
            errors++; $display("FAIL pol_err: got %b want 010", {s2_er[5], s2_er[6], s2_lk[6]});
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        send_line(0, 4, 1'b1, 0, 1'b0);
        send_line(16, 4, 1'b0, 0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
        rst = 1'b0;
        checks++;
        if ({p1_valid, p1_x, p1_y, p1_h, p1_v, p1_vt, p1_crc, p1_cnt, p1_locked, p1_err} !== '0) begin
            errors++; $display("FAIL rmid_zero: got nonzero outputs want 0");
        end
        d0 = done1;
        for (int l = 2; l < 6; l++) send_line(16, 4, 1'b0, l - 1, 1'b0);
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if (done1 != d0 || p1_cnt !== 8'd0) begin
            errors++; $display("FAIL rmid_no_done: got dones=%0d cnt=%0d want %0d 0", done1, p1_cnt, d0);
        end
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if (done1 != d0 + 1) begin errors++; $display("FAIL rmid_done: got %0d want %0d", done1, d0 + 1); end
        checks++;
        if ({p1_h, p1_v, p1_vt, p1_cnt, p1_locked, p1_err} !== {11'd16, 10'd4, 10'd6, 8'd1, 2'b00}) begin
            errors++; $display("FAIL rmid_frame: got H=%0d V=%0d VT=%0d cnt=%0d lk/err=%b want 16 4 6 1 00",
                               p1_h, p1_v, p1_vt, p1_cnt, {p1_locked, p1_err});
        end
    endtask

    task automatic test_coincident;
        send_frame(16, 1'b0, 1'b1);
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if ({p1_h, p1_v, p1_vt} !== {11'd16, 10'd5, 10'd6}) begin
            errors++; $display("FAIL coinc_geom: got H=%0d V=%0d VT=%0d want 16 5 6", p1_h, p1_v, p1_vt);
        end
        checks++;
        if ({p1_locked, p1_err} !== 2'b00) begin
            errors++; $display("FAIL coinc_status: got lock/err=%b want 00", {p1_locked, p1_err});
        end
        send_frame(16, 1'b0, 1'b0);
        checks++;
        if (p1_v !== 10'd4) begin errors++; $display("FAIL coinc_next: got V=%0d want 4", p1_v); end
    endtask

    initial begin
        test_reset;
        test_geometry;
        test_pixel;
        test_error;
        test_polarity;
        test_reset_mid;
        test_coincident;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
